// File: rtl/button_encoder_pkg.sv
// -----------------------------------------------------------------------------
// button_encoder_pkg
//   Shared game constants for the pad/button front end: pad count, pad index
//   width, default debounce length, the arbitration state encoding and two
//   small helpers that summarise a debounced pad vector.
//   No ports (package).
// -----------------------------------------------------------------------------
package button_encoder_pkg;

   localparam int unsigned NUM_PADS               = 4;
   localparam int unsigned PAD_IDX_W              = 2;
   // 3 ticks of the 60 Hz game clock, roughly 50 ms
   localparam int unsigned DEBOUNCE_TICKS_DEFAULT = 3;

   typedef enum logic [1:0] {
      IDLE,
      HELD,
      RELEASE
   } padState_t;

   // Number of pads currently high (0..NUM_PADS)
   function automatic logic [2:0] countHigh(input logic [NUM_PADS-1:0] pads);
      logic [2:0] n;
      n = '0;
      for (int unsigned i = 0; i < NUM_PADS; i++) begin
         n = n + {2'b00, pads[i]};
      end
      return n;
   endfunction

   // Index of the highest pad that is high; only meaningful for a one-hot vector
   function automatic logic [PAD_IDX_W-1:0] highIndex(input logic [NUM_PADS-1:0] pads);
      logic [PAD_IDX_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < NUM_PADS; i++) begin
         if (pads[i]) begin
            idx = PAD_IDX_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/button_encoder_debounce.sv
// -----------------------------------------------------------------------------
// button_encoder_debounce
//   One pad bit: 2-flop synchronizer followed by a hold counter. The debounced
//   level only follows the synchronized level after it has differed for
//   DEBOUNCE_TICKS consecutive cycles; any shorter excursion is discarded.
//   Ports:
//     clk     in   system clock, rising edge
//     reset   in   asynchronous active-low reset
//     btnRaw  in   raw asynchronous pad input
//     level   out  debounced level
// -----------------------------------------------------------------------------
module button_encoder_debounce
   import button_encoder_pkg::*;
#(
   parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic btnRaw,
   output logic level
);

   localparam int unsigned CNT_W = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS + 1);

   logic             syncA;
   logic             syncB;
   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         syncA <= 1'b0;
         syncB <= 1'b0;
         count <= '0;
         level <= 1'b0;
      end else begin
         syncA <= btnRaw;
         syncB <= syncA;
         if (syncB == level) begin
            count <= '0;
         end else if (count == CNT_W'(DEBOUNCE_TICKS - 1)) begin
            // this edge would bring the count to DEBOUNCE_TICKS: accept the level
            level <= syncB;
            count <= '0;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/button_encoder.sv
// -----------------------------------------------------------------------------
// button_encoder
//   Debounces the four pad buttons and arbitrates them into a single accepted
//   press for the game logic. A lone press outside Simon's turn is latched as
//   playerNum with playerPressed held for its duration; simultaneous presses
//   produce a multiPress pulse and are ignored until all pads are released.
//   Ports:
//     clk            in   system clock (60 Hz), rising edge
//     reset          in   asynchronous active-low reset
//     btn[3:0]       in   raw active-high pad buttons, bit i = pad i
//     simonTurn      in   high while the game plays its own sequence
//     playerNum[1:0] out  index of the accepted pad, stable for the press
//     playerPressed  out  high while the accepted pad is held
//     multiPress     out  one-cycle pulse on a multi-pad press in IDLE
// -----------------------------------------------------------------------------
module button_encoder
   import button_encoder_pkg::*;
#(
   parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_PADS-1:0]  btn,
   input  logic                 simonTurn,
   output logic [PAD_IDX_W-1:0] playerNum,
   output logic                 playerPressed,
   output logic                 multiPress
);

   logic [NUM_PADS-1:0]  debLevel;
   logic [NUM_PADS-1:0]  debQ;
   padState_t            state;
   padState_t            nextState;
   logic [PAD_IDX_W-1:0] nextNum;
   logic                 nextPressed;
   logic                 nextMulti;
   logic [2:0]           nHigh;

   for (genvar i = 0; i < NUM_PADS; i++) begin : padDeb
      button_encoder_debounce #(
         .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
      ) uDeb (
         .clk    (clk),
         .reset  (reset),
         .btnRaw (btn[i]),
         .level  (debLevel[i])
      );
   end

   // debQ registers the debounced vector so the arbitration sees all pads
   // from one aligned sample; this stage sets the DEBOUNCE_TICKS+3 latency.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         debQ          <= '0;
         state         <= IDLE;
         playerNum     <= '0;
         playerPressed <= 1'b0;
         multiPress    <= 1'b0;
      end else begin
         debQ          <= debLevel;
         state         <= nextState;
         playerNum     <= nextNum;
         playerPressed <= nextPressed;
         multiPress    <= nextMulti;
      end
   end

   always_comb begin
      nextState   = state;
      nextNum     = playerNum;
      nextPressed = playerPressed;
      nextMulti   = 1'b0;
      nHigh       = countHigh(debQ);

      case (state)
         IDLE: begin
            nextPressed = 1'b0;
            if (nHigh != 3'd0) begin
               if (simonTurn) begin
                  // press began during Simon's turn: wait for full release
                  nextState = RELEASE;
               end else if (nHigh == 3'd1) begin
                  nextState   = HELD;
                  nextNum     = highIndex(debQ);
                  nextPressed = 1'b1;
               end else begin
                  nextState = RELEASE;
                  nextMulti = 1'b1;
               end
            end
         end

         HELD: begin
            // only the accepted pad ends the press; simonTurn is not looked at
            if (!debQ[playerNum]) begin
               nextState   = IDLE;
               nextPressed = 1'b0;
            end
         end

         RELEASE: begin
            nextPressed = 1'b0;
            if (debQ == '0) begin
               nextState = IDLE;
            end
         end

         default: begin
            nextState   = IDLE;
            nextPressed = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_button_encoder.sv
// -----------------------------------------------------------------------------
// tb_button_encoder
//   Scoreboard bench for button_encoder with DEBOUNCE_TICKS = 3. Stimulus is
//   applied on the falling edge; each drive pushes the outputs it should cause,
//   stamped with the rising-edge number at which they become visible. The
//   monitor samples 1 time unit after every rising edge and pops due entries.
// -----------------------------------------------------------------------------
module tb_button_encoder;

   localparam int F_PRESSED = 0;
   localparam int F_NUM     = 1;
   localparam int F_MULTI   = 2;
   localparam int F_DEB     = 3;

   logic       clk       = 1'b0;
   logic       reset     = 1'b1;
   logic [3:0] btn       = 4'b0000;
   logic       simonTurn = 1'b0;
   logic [1:0] playerNum;
   logic       playerPressed;
   logic       multiPress;

   button_encoder #(
      .DEBOUNCE_TICKS(3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .btn           (btn),
      .simonTurn     (simonTurn),
      .playerNum     (playerNum),
      .playerPressed (playerPressed),
      .multiPress    (multiPress)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      string      tag;
      int         field;
      logic [3:0] val;
   } expT;

   expT sb[$];
   int  cyc       = 0;
   int  nCompared = 0;
   int  nMismatch = 0;

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nCompared++;
      if (obs !== expv) begin
         nMismatch++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, obs, expv);
      end
   endtask

   function automatic logic [31:0] observe(input int field);
      case (field)
         F_PRESSED: return {31'd0, playerPressed};
         F_NUM:     return {30'd0, playerNum};
         F_MULTI:   return {31'd0, multiPress};
         default:   return {28'd0, dut.debLevel};
      endcase
   endfunction

   task automatic expectAt(input int atCyc, input string tag, input int field, input logic [3:0] val);
      expT e;
      int  i;
      e.cyc   = atCyc;
      e.tag   = tag;
      e.field = field;
      e.val   = val;
      i = 0;
      while (i < sb.size() && sb[i].cyc <= atCyc) i++;
      sb.insert(i, e);
   endtask

   task automatic expectSpan(input int fromCyc, input int toCyc, input string tag,
                             input int field, input logic [3:0] val);
      for (int c = fromCyc; c <= toCyc; c++) expectAt(c, tag, field, val);
   endtask

   // Apply inputs on the next falling edge; e0 is the first rising edge that samples them
   task automatic drive(input logic [3:0] b, input logic st, output int e0);
      @(negedge clk);
      btn       = b;
      simonTurn = st;
      e0        = cyc + 1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: sample just after each rising edge and compare due entries
   initial begin
      expT e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checkEq(e.tag, observe(e.field), {28'd0, e.val});
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      int e0;
      int r0;
      int t;

      // reset state
      #2 reset = 1'b0;
      idle(3);
      checkEq("rst_pressed", {31'd0, playerPressed}, 0);
      checkEq("rst_num",     {30'd0, playerNum},     0);
      checkEq("rst_multi",   {31'd0, multiPress},    0);
      checkEq("rst_deb",     {28'd0, dut.debLevel},  0);
      @(negedge clk) reset = 1'b1;
      idle(2);

      // single press of pad 2, 20 cycles, then release
      drive(4'b0100, 1'b0, e0);
      expectAt(e0 + 5, "A_pre",   F_PRESSED, 4'd0);
      expectAt(e0 + 6, "A_rise",  F_PRESSED, 4'd1);
      expectAt(e0 + 6, "A_num",   F_NUM,     4'd2);
      expectAt(e0 + 6, "A_multi", F_MULTI,   4'd0);
      idle(19);
      drive(4'b0000, 1'b0, r0);
      expectAt(r0 + 5, "A_hold",    F_PRESSED, 4'd1);
      expectAt(r0 + 6, "A_fall",    F_PRESSED, 4'd0);
      expectAt(r0 + 6, "A_numKeep", F_NUM,     4'd2);
      idle(12);

      // 2-cycle glitch on pad 1 never debounces
      drive(4'b0010, 1'b0, e0);
      expectSpan(e0, e0 + 12, "B_deb",     F_DEB,     4'd0);
      expectSpan(e0, e0 + 12, "B_pressed", F_PRESSED, 4'd0);
      idle(1);
      drive(4'b0000, 1'b0, r0);
      idle(14);

      // pads 0 and 1 together: one multiPress pulse, no acceptance
      drive(4'b0011, 1'b0, e0);
      expectAt(e0 + 5, "C_multiPre",  F_MULTI, 4'd0);
      expectAt(e0 + 6, "C_multi",     F_MULTI, 4'd1);
      expectAt(e0 + 7, "C_multiOff",  F_MULTI, 4'd0);
      expectAt(e0 + 6, "C_numKeep",   F_NUM,   4'd2);
      expectSpan(e0, e0 + 14, "C_noPress", F_PRESSED, 4'd0);
      idle(12);
      drive(4'b0000, 1'b0, r0);
      expectSpan(r0, r0 + 8, "C_relNoPress", F_PRESSED, 4'd0);
      idle(10);
      drive(4'b0001, 1'b0, e0);
      expectAt(e0 + 5, "C_pad0Pre", F_PRESSED, 4'd0);
      expectAt(e0 + 6, "C_pad0",    F_PRESSED, 4'd1);
      expectAt(e0 + 6, "C_pad0Num", F_NUM,     4'd0);
      idle(9);
      drive(4'b0000, 1'b0, r0);
      expectAt(r0 + 6, "C_pad0Fall", F_PRESSED, 4'd0);
      idle(10);

      // pad 3 held, pad 1 added, pad 3 released -> pad 1 accepted next
      drive(4'b1000, 1'b0, e0);
      expectAt(e0 + 6, "D_rise", F_PRESSED, 4'd1);
      expectAt(e0 + 6, "D_num3", F_NUM,     4'd3);
      idle(9);
      drive(4'b1010, 1'b0, t);
      expectAt(t + 10, "D_otherIgn", F_NUM,     4'd3);
      expectAt(t + 10, "D_stillOn",  F_PRESSED, 4'd1);
      idle(9);
      drive(4'b0010, 1'b0, r0);
      expectAt(r0 + 5, "D_hold",    F_PRESSED, 4'd1);
      expectAt(r0 + 6, "D_fall",    F_PRESSED, 4'd0);
      expectAt(r0 + 6, "D_numKeep", F_NUM,     4'd3);
      expectAt(r0 + 7, "D_pad1",    F_PRESSED, 4'd1);
      expectAt(r0 + 7, "D_num1",    F_NUM,     4'd1);
      idle(9);
      drive(4'b0000, 1'b0, r0);
      expectAt(r0 + 6, "D_pad1Fall", F_PRESSED, 4'd0);
      idle(10);

      // press during simonTurn is never accepted, even after simonTurn falls
      drive(4'b0001, 1'b1, e0);
      expectSpan(e0, e0 + 26, "E_simonBlock", F_PRESSED, 4'd0);
      idle(9);
      drive(4'b0001, 1'b0, t);
      idle(9);
      drive(4'b0000, 1'b0, r0);
      idle(10);
      drive(4'b0001, 1'b0, e0);
      expectAt(e0 + 6, "E_rePress", F_PRESSED, 4'd1);
      expectAt(e0 + 6, "E_num0",    F_NUM,     4'd0);
      // simonTurn rising during HELD does not truncate the press
      idle(7);
      drive(4'b0001, 1'b1, t);
      idle(9);
      drive(4'b0000, 1'b1, r0);
      expectAt(r0 + 5, "E_noTrunc", F_PRESSED, 4'd1);
      expectAt(r0 + 6, "E_fall",    F_PRESSED, 4'd0);
      idle(10);
      drive(4'b0000, 1'b0, t);
      idle(5);

      // reset during HELD drops the press at once; held pad re-debounces afterwards
      drive(4'b0100, 1'b0, e0);
      expectAt(e0 + 6, "F_rise", F_PRESSED, 4'd1);
      idle(9);
      @(negedge clk) reset = 1'b0;
      #1;
      checkEq("F_rstPressed", {31'd0, playerPressed}, 0);
      checkEq("F_rstNum",     {30'd0, playerNum},     0);
      checkEq("F_rstDeb",     {28'd0, dut.debLevel},  0);
      idle(2);
      @(negedge clk) reset = 1'b1;
      e0 = cyc + 1;
      expectAt(e0 + 5, "F_reDebPre", F_PRESSED, 4'd0);
      expectAt(e0 + 6, "F_reAccept", F_PRESSED, 4'd1);
      expectAt(e0 + 6, "F_reNum",    F_NUM,     4'd2);
      idle(9);
      drive(4'b0000, 1'b0, r0);
      expectAt(r0 + 6, "F_fall", F_PRESSED, 4'd0);
      idle(10);

      checkEq("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
